// File: rtl/avr_spi_cmd_pkg.sv
// Shared constants for the AVR command link receiver: address nibbles,
// FSM states and the LSB-first shift helper.
package avr_spi_pkg;

  localparam logic [3:0] ADDR_KBD  = 4'h1;
  localparam logic [3:0] ADDR_MUS  = 4'h2;
  localparam logic [3:0] ADDR_RST  = 4'h3;
  localparam logic [3:0] ADDR_CFG0 = 4'h5;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } spi_state_e;

  // Bits arrive LSB first, so each new bit enters at the top.
  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b);
    return {b, r[7:1]};
  endfunction

endpackage

// File: rtl/avr_spi_cmd_if.sv
// AVR command link wires: AVR drives cs/clock/data, FPGA returns spidi.
interface avr_spi_cmd_if;
  logic spics_n;
  logic spick;
  logic spido;
  logic spidi;

  modport master (output spics_n, output spick, output spido, input spidi);
  modport slave  (input spics_n, input spick, input spido, output spidi);
endinterface

// File: rtl/avr_spi_cmd_sync.sv
// Input synchronizer plus one-flop edge detector for an async link wire.
// Everything resets to 1 so an idle (high) line shows no edge at reset exit.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchronizer chain followed by the delayed copy used for edge compare.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~dly_q;
  assign fall = ~lvl & dly_q;

endmodule

// File: rtl/avr_spi_cmd.sv
// AVR command link receiver: shifts an address byte while cs is high and a
// data byte while cs is low, commits on cs rise to registers and strobes,
// and returns cfg0 on spidi during a cfg0-addressed data phase.
module avr_spi_cmd
  import avr_spi_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] CFG0_RST      = 8'h00,
  parameter logic       SCANLINES_RST = 1'b1
) (
  input  logic         fclk,
  input  logic         rst_n,
  avr_spi_cmd_if.slave spi,
  output logic [7:0]   kbd_data,
  output logic         kbd_stb,
  output logic [7:0]   mus_x,
  output logic [7:0]   mus_y,
  output logic         mus_x_stb,
  output logic         mus_y_stb,
  output logic         game_rst_stb,
  output logic [7:0]   cfg0,
  output logic         vga_mode,
  output logic         scanlines
);

  logic cs_s, cs_rise, cs_fall;
  logic ck_s, ck_rise, ck_fall;
  logic do_s, do_rise, do_fall;
  logic cs_edge;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .fclk(fclk), .rst_n(rst_n), .din(spi.spics_n),
    .lvl(cs_s), .rise(cs_rise), .fall(cs_fall));

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ck (
    .fclk(fclk), .rst_n(rst_n), .din(spi.spick),
    .lvl(ck_s), .rise(ck_rise), .fall(ck_fall));

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_do (
    .fclk(fclk), .rst_n(rst_n), .din(spi.spido),
    .lvl(do_s), .rise(do_rise), .fall(do_fall));

  // Phase is tracked from cs edges; levels of cs/clock and data edges are not needed.
  logic unused_sync;
  assign unused_sync = ^{cs_s, ck_s, do_rise, do_fall};

  // A cs edge takes priority over any clock edge seen in the same cycle.
  assign cs_edge = cs_rise | cs_fall;

  spi_state_e state_q, state_d;
  logic [7:0] addr_q, data_q, tx_q;
  logic       spidi_q;
  logic       load_tx, sh_addr, sh_data, sh_tx, commit;

  // State register.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ADDR;
    else        state_q <= state_d;
  end

  // Next state and per-cycle datapath controls.
  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    sh_addr = 1'b0;
    sh_data = 1'b0;
    sh_tx   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_ADDR: begin
        if (cs_fall) begin
          state_d = ST_DATA;
          load_tx = 1'b1;
        end else if (!cs_edge) begin
          sh_addr = ck_rise;
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          state_d = ST_ADDR;
          commit  = 1'b1;
        end else if (!cs_edge) begin
          sh_data = ck_rise;
          sh_tx   = ck_fall;
        end
      end
      default: state_d = ST_ADDR;
    endcase
  end

  // Shift registers, readback and the commit decode into outputs/strobes.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      data_q       <= '0;
      tx_q         <= '0;
      spidi_q      <= 1'b0;
      kbd_data     <= '0;
      kbd_stb      <= 1'b0;
      mus_x        <= '0;
      mus_y        <= '0;
      mus_x_stb    <= 1'b0;
      mus_y_stb    <= 1'b0;
      game_rst_stb <= 1'b0;
      cfg0         <= CFG0_RST;
      scanlines    <= SCANLINES_RST;
    end else begin
      kbd_stb      <= 1'b0;
      mus_x_stb    <= 1'b0;
      mus_y_stb    <= 1'b0;
      game_rst_stb <= 1'b0;
      spidi_q      <= (state_q == ST_DATA) ? tx_q[0] : 1'b0;

      if (sh_addr) addr_q <= shift_in(addr_q, do_s);
      if (sh_data) data_q <= shift_in(data_q, do_s);
      if (sh_tx)   tx_q   <= {1'b0, tx_q[7:1]};

      if (load_tx) begin
        data_q <= '0;
        tx_q   <= (addr_q[7:4] == ADDR_CFG0) ? cfg0 : 8'h00;
      end

      if (commit) begin
        addr_q <= '0;
        unique case (addr_q[7:4])
          ADDR_KBD: begin
            if (addr_q[0]) kbd_stb  <= 1'b1;
            else           kbd_data <= data_q;
          end
          ADDR_MUS: begin
            if (addr_q[1:0] == 2'b00) begin
              mus_x     <= data_q;
              mus_x_stb <= 1'b1;
            end else if (addr_q[1:0] == 2'b01) begin
              mus_y     <= data_q;
              mus_y_stb <= 1'b1;
            end
          end
          ADDR_RST: game_rst_stb <= 1'b1;
          ADDR_CFG0: begin
            // Scanlines flip only on a 0->1 of the video mode bit.
            if (data_q[0] && !cfg0[0]) scanlines <= ~scanlines;
            cfg0 <= data_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign spi.spidi = spidi_q;
  assign vga_mode  = cfg0[0];

endmodule
